// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RV32 load/store funct3
// codes, controller FSM states and the response record carried down the latency pipe.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for RV32 accesses: store byte enables and data
// replication, load lane extraction with sign/zero extension, and size/alignment faults.
module mem_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [31:0] shifted;

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    err       = 1'b0;
    shifted   = rword >> {lane, 3'b000};
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'b0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'b0, shifted[15:0]};
        err       = lane[0];
      end
      F3_W: begin
        be        = '1;
        wdata_rep = wdata;
        rdata_ext = rword;
        err       = |lane;
      end
      default: err = 1'b1;
    endcase
    // Unsigned sizes are load-only encodings.
    if (we && funct3[2]) err = 1'b1;
    if (err) be = '0;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked RV32 data memory: optional post-reset zero clear, per-byte writes,
// and loads returned through an RD_LAT-deep response pipeline.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 1024,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_q, clr_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  rsp_t            pipe_q [RD_LAT];
  rsp_t            pipe_d [RD_LAT];

  logic            accept, range_err, align_err, req_err, wr_en;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [31:0]     wdata_rep, ld_data;

  assign req_ready = (state_q == RUN);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[AW+1:2];
  assign range_err = |req_addr[XLEN-1:AW+2];
  assign req_err   = range_err | align_err;
  assign wr_en     = accept && req_we && !req_err;

  mem_align u_align (
    .we        (req_we),
    .funct3    (req_funct3),
    .lane      (req_addr[1:0]),
    .wdata     (req_wdata),
    .rword     (mem_q[idx]),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (ld_data),
    .err       (align_err)
  );

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == CLEAR) begin
      clr_d = clr_q + AW'(1);
      if (clr_q == AW'(DEPTH - 1)) state_d = RUN;
    end
  end

  always_comb begin
    pipe_d[0] = '0;
    if (accept) begin
      pipe_d[0].valid = 1'b1;
      pipe_d[0].err   = req_err;
      pipe_d[0].rdata = (req_we || req_err) ? '0 : ld_data;
    end
    for (int unsigned i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
      clr_q   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // The array has no reset; the CLEAR sweep is the only thing that initialises it.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  assign rsp_valid = pipe_q[RD_LAT-1].valid;
  assign rsp_rdata = pipe_q[RD_LAT-1].rdata;
  assign rsp_err   = pipe_q[RD_LAT-1].err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: three configurations share one request bus,
// checked with directed tables and a byte-array reference model under random traffic.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  int          sel;

  logic        va, vb, vc;
  logic        ready_a, ready_b, ready_c, valid_a, valid_b, valid_c, err_a, err_b, err_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [3][4096];

  typedef struct {
    int          s;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        er;
  } step_t;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  always #5 clk = ~clk;

  assign va = req_valid && (sel == 0);
  assign vb = req_valid && (sel == 1);
  assign vc = req_valid && (sel == 2);

  dmem_ctrl #(.XLEN(32), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(va), .req_ready(ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(valid_a), .rsp_rdata(rdata_a), .rsp_err(err_a));

  dmem_ctrl #(.XLEN(32), .DEPTH(1024), .RD_LAT(3), .CLEAR_ON_RST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_ready(ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(valid_b), .rsp_rdata(rdata_b), .rsp_err(err_b));

  dmem_ctrl #(.XLEN(32), .DEPTH(16), .RD_LAT(4), .CLEAR_ON_RST(1)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(vc), .req_ready(ready_c), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(valid_c), .rsp_rdata(rdata_c), .rsp_err(err_c));

  always_comb begin
    m_ready = ready_a; m_valid = valid_a; m_rdata = rdata_a; m_err = err_a;
    if (sel == 1) begin
      m_ready = ready_b; m_valid = valid_b; m_rdata = rdata_b; m_err = err_b;
    end else if (sel == 2) begin
      m_ready = ready_c; m_valid = valid_c; m_rdata = rdata_c; m_err = err_c;
    end
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 4;
  endfunction

  // Architectural model: memory is a flat byte array, accesses are little-endian.
  function automatic void model(input int s, input logic we, input logic [31:0] addr,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int nb;
    bit legal;
    int total;
    total = (s == 1) ? 4096 : 64;
    nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    er    = !legal || (addr >= 32'(total)) || ((addr % nb) != 0);
    rd    = '0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[s][addr + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[s][addr + i];
      if (f3 < 3'd4 && nb < 4 && rd[8*nb-1])
        for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hFF;
    end
  endfunction

  // Drives one request on the selected instance and collects what comes back.
  task automatic access(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, output int k_first, output int cnt,
                        output logic [31:0] rd, output logic er, output bit leak);
    logic [31:0] mrd;
    logic        mer;
    int          n = 0;
    int          lat;
    lat = lat_of(sel);
    model(sel, we, addr, f3, wd, mrd, mer);
    k_first = 0; cnt = 0; rd = '0; er = 1'b0; leak = 1'b0;
    while (m_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        cnt++;
        if (k_first == 0) begin
          k_first = k; rd = m_rdata; er = m_err;
        end
      end else if (m_rdata !== '0 || m_err !== 1'b0) begin
        leak = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    int  cnt = 0;
    bit  spur = 0;
    int  k, c;
    logic [31:0] rd;
    logic er;
    bit lk;
    sel = 0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready_a, ready_b, ready_c, valid_a, valid_b, valid_c, err_a, err_b, err_c} !== 9'b010000000 ||
        (rdata_a | rdata_b | rdata_c) !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b%b%b valid=%b%b%b err=%b%b%b rdata_or=%h; want ready=010 valid=000 err=000 rdata_or=0",
               ready_a, ready_b, ready_c, valid_a, valid_b, valid_c, err_a, err_b, err_c,
               rdata_a | rdata_b | rdata_c);
    end
    // A store held on the bus during the clear must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h3C; req_funct3 = F3_W; req_wdata = '1;
    rst_n = 1'b1;
    while (ready_a !== 1'b1 && cnt < 100) begin
      if (valid_a !== 1'b0) spur = 1;
      cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_checks++;
    if (cnt != 16 || ready_c !== 1'b1 || spur) begin
      n_fail++;
      $display("FAIL clear_len: ready low for %0d cycles, ready_c=%b spur=%b; want 16, ready_c=1 spur=0",
               cnt, ready_c, spur);
    end
    access(1'b0, 32'h3C, F3_W, '0, k, c, rd, er, lk);
    n_checks++;
    if (k != 1 || c != 1 || rd !== 32'h0 || er !== 1'b0 || lk) begin
      n_fail++;
      $display("FAIL clear_read: k=%0d cnt=%0d rdata=%h err=%b leak=%b; want k=1 cnt=1 rdata=00000000 err=0",
               k, c, rd, er, lk);
    end
  endtask

  task automatic test_sized();
    step_t tbl [6];
    int k, c;
    logic [31:0] rd;
    logic er;
    bit lk;
    tbl = '{'{0, 1'b1, 32'h0, F3_W,  32'h8081_7F01, 32'h0,         1'b0},
            '{0, 1'b0, 32'h0, F3_B,  32'h0,         32'h0000_0001, 1'b0},
            '{0, 1'b0, 32'h3, F3_B,  32'h0,         32'hFFFF_FF80, 1'b0},
            '{0, 1'b0, 32'h3, F3_BU, 32'h0,         32'h0000_0080, 1'b0},
            '{0, 1'b0, 32'h2, F3_H,  32'h0,         32'hFFFF_8081, 1'b0},
            '{0, 1'b0, 32'h0, F3_HU, 32'h0,         32'h0000_7F01, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      sel = tbl[i].s;
      access(tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, k, c, rd, er, lk);
      n_checks++;
      if (k != lat_of(sel) || c != 1 || rd !== tbl[i].exp || er !== tbl[i].er || lk) begin
        n_fail++;
        $display("FAIL sized[%0d]: k=%0d cnt=%0d rdata=%h err=%b leak=%b; want k=%0d cnt=1 rdata=%h err=%b",
                 i, k, c, rd, er, lk, lat_of(sel), tbl[i].exp, tbl[i].er);
      end
    end
  endtask

  task automatic test_byte_lane();
    step_t tbl [4];
    int k, c;
    logic [31:0] rd;
    logic er;
    bit lk;
    tbl = '{'{0, 1'b1, 32'h4, F3_W, 32'h1122_3344, 32'h0,         1'b0},
            '{0, 1'b1, 32'h5, F3_B, 32'hFFFF_FFAA, 32'h0,         1'b0},
            '{0, 1'b1, 32'h6, F3_H, 32'h7777_BEEF, 32'h0,         1'b0},
            '{0, 1'b0, 32'h4, F3_W, 32'h0,         32'hBEEF_AA44, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      sel = tbl[i].s;
      access(tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, k, c, rd, er, lk);
      n_checks++;
      if (k != lat_of(sel) || c != 1 || rd !== tbl[i].exp || er !== tbl[i].er || lk) begin
        n_fail++;
        $display("FAIL byte_lane[%0d]: k=%0d cnt=%0d rdata=%h err=%b leak=%b; want k=%0d cnt=1 rdata=%h err=%b",
                 i, k, c, rd, er, lk, lat_of(sel), tbl[i].exp, tbl[i].er);
      end
    end
  endtask

  task automatic test_errors();
    step_t tbl [9];
    int k, c;
    logic [31:0] rd;
    logic er;
    bit lk;
    tbl = '{'{0, 1'b0, 32'h2,    F3_W,  32'h0,         32'h0,         1'b1},
            '{0, 1'b1, 32'h1,    F3_H,  32'hFFFF_FFFF, 32'h0,         1'b1},
            '{0, 1'b0, 32'h0,    3'd3,  32'h0,         32'h0,         1'b1},
            '{0, 1'b1, 32'h40,   F3_W,  32'hFFFF_FFFF, 32'h0,         1'b1},
            '{0, 1'b1, 32'h0,    F3_BU, 32'hFFFF_FFFF, 32'h0,         1'b1},
            '{0, 1'b0, 32'h0,    F3_W,  32'h0,         32'h8081_7F01, 1'b0},
            '{1, 1'b1, 32'h0,    F3_W,  32'hCAFE_F00D, 32'h0,         1'b0},
            '{1, 1'b1, 32'h1000, F3_W,  32'h0000_DEAD, 32'h0,         1'b1},
            '{1, 1'b0, 32'h0,    F3_W,  32'h0,         32'hCAFE_F00D, 1'b0}};
    for (int i = 0; i < 9; i++) begin
      sel = tbl[i].s;
      access(tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, k, c, rd, er, lk);
      n_checks++;
      if (k != lat_of(sel) || c != 1 || rd !== tbl[i].exp || er !== tbl[i].er || lk) begin
        n_fail++;
        $display("FAIL errors[%0d]: k=%0d cnt=%0d rdata=%h err=%b leak=%b; want k=%0d cnt=1 rdata=%h err=%b",
                 i, k, c, rd, er, lk, lat_of(sel), tbl[i].exp, tbl[i].er);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vbits = '0;
    logic [31:0] rdv [8];
    logic        erv [8];
    logic [31:0] mrd;
    logic        mer;
    sel = 1;
    model(1, 1'b1, 32'h8, F3_W, 32'd5, mrd, mer);
    model(1, 1'b0, 32'h8, F3_W, 32'd0, mrd, mer);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_funct3 = F3_W; req_wdata = 32'd5;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = '0;
    @(negedge clk);
    vbits[1] = m_valid; rdv[1] = m_rdata; erv[1] = m_err;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      vbits[k] = m_valid; rdv[k] = m_rdata; erv[k] = m_err;
    end
    n_checks++;
    if (vbits !== 8'b0001_1000) begin
      n_fail++;
      $display("FAIL b2b_timing: valid pattern %b; want 00011000", vbits);
    end
    n_checks++;
    if (rdv[3] !== 32'h0 || erv[3] !== 1'b0 || rdv[4] !== 32'd5 || erv[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_data: store rsp %h/%b load rsp %h/%b; want 00000000/0 then 00000005/0",
               rdv[3], erv[3], rdv[4], erv[4]);
    end
  endtask

  task automatic test_random(input int s, input int n);
    exp_t        q [$];
    exp_t        e;
    logic [31:0] addr, wd, mrd;
    logic [2:0]  f3;
    logic        we, mer;
    int          lat;
    sel = s;
    lat = lat_of(s);
    for (int c = 0; c <= n + lat + 1; c++) begin
      if (q.size() > 0 && q[0].due == c) begin
        e = q.pop_front();
        n_checks++;
        if (m_valid !== 1'b1 || m_rdata !== e.rd || m_err !== e.er) begin
          n_fail++;
          $display("FAIL rand%0d c=%0d: valid=%b rdata=%h err=%b; want valid=1 rdata=%h err=%b",
                   s, c, m_valid, m_rdata, m_err, e.rd, e.er);
        end
      end else begin
        n_checks++;
        if (m_valid !== 1'b0 || m_rdata !== '0 || m_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rand%0d_idle c=%0d: valid=%b rdata=%h err=%b; want 0/0/0",
                   s, c, m_valid, m_rdata, m_err);
        end
      end
      if (c < n) begin
        wd = $urandom;
        if (s == 1 && c < 16) begin
          we = 1'b1; f3 = F3_W; addr = 32'(4 * c);
        end else begin
          we = 1'($urandom % 2);
          f3 = 3'($urandom % 8);
          if (s == 1) addr = ($urandom % 8 == 0) ? 32'h1000 + ($urandom % 64) : ($urandom % 64);
          else        addr = $urandom_range(0, 71);
        end
        model(s, we, addr, f3, wd, mrd, mer);
        q.push_back('{c + lat, mrd, mer});
        req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rand%0d_drain: %0d responses outstanding; want 0", s, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    bit  seen = 0;
    int  cnt = 0;
    int  k, c;
    logic [31:0] rd;
    logic er;
    bit lk;
    sel = 2;
    access(1'b1, 32'h8, F3_W, 32'h1234_5678, k, c, rd, er, lk);
    n_checks++;
    if (k != 4 || c != 1 || rd !== 32'h0 || er !== 1'b0 || lk) begin
      n_fail++;
      $display("FAIL mid_store: k=%0d cnt=%0d rdata=%h err=%b leak=%b; want k=4 cnt=1 rdata=00000000 err=0",
               k, c, rd, er, lk);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_funct3 = F3_W;
    @(posedge clk);
    #1 req_addr = 32'hC;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (valid_c !== 1'b0) seen = 1;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (valid_c !== 1'b0) seen = 1;
    end
    rst_n = 1'b1;
    while (ready_c !== 1'b1 && cnt < 100) begin
      if (valid_c !== 1'b0) seen = 1;
      cnt++;
      @(negedge clk);
    end
    repeat (6) begin
      if (valid_c !== 1'b0) seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (seen || cnt != 16) begin
      n_fail++;
      $display("FAIL mid_reset: stray rsp_valid=%b clear cycles=%0d; want 0 and 16", seen, cnt);
    end
    access(1'b0, 32'h8, F3_W, '0, k, c, rd, er, lk);
    n_checks++;
    if (k != 4 || c != 1 || rd !== 32'h0 || er !== 1'b0 || lk) begin
      n_fail++;
      $display("FAIL mid_recleared: k=%0d cnt=%0d rdata=%h err=%b leak=%b; want k=4 cnt=1 rdata=00000000 err=0",
               k, c, rd, er, lk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 4096; i++) ref_mem[s][i] = 8'h00;
    test_reset();
    test_sized();
    test_byte_lane();
    test_errors();
    test_back_to_back();
    test_random(0, 150);
    test_random(1, 150);
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, handshaked data memory for the RISC-V core's load/store path, succeeding the flat word-only `dmem`. It accepts byte-addressed requests with RV32 load/store sizing (B/H/W, signed/unsigned), performs byte-lane writes, and returns load data after a configurable read latency. It flags misaligned, illegal-size and out-of-range accesses, and can zero-clear its array after reset. It sits between the core's memory stage and the data RAM, with `imem` unchanged alongside it.

## Interface
- `XLEN`, 32: data and address width; only 32 supported.
- `DEPTH`, 1024: number of words; power of two, ≥4.
- `RD_LAT`, 1: response latency in cycles, 1..4.
- `CLEAR_ON_RST`, 1: 1 = zero the array after reset before accepting requests.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  XLEN  byte address.
- `req_funct3`  in  3  RV32 funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `req_wdata`  in  XLEN  store data, right-aligned.
- `rsp_valid`  out  1  response present; one cycle per accepted request.
- `rsp_rdata`  out  XLEN  load result, sign/zero-extended; 0 for stores and errors.
- `rsp_err`  out  1  access faulted.

## Operation
- Accept: `req_valid && req_ready` at a rising edge. No response backpressure; the consumer must take `rsp_valid` when it is asserted.
- FSM states:
  - CLEAR: entered on reset when `CLEAR_ON_RST`=1. A counter writes 0 to words 0..DEPTH-1, one per cycle, then moves to RUN. `req_ready`=0 throughout.
  - RUN: `req_ready`=1. Reset with `CLEAR_ON_RST`=0 enters RUN directly.
- Word index = `req_addr[log2(DEPTH)+1:2]`; byte lane = `req_addr[1:0]`. Little-endian.
- Error if any of the following hold:
  - `req_addr[XLEN-1:log2(DEPTH)+2]` ≠ 0.
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - funct3 ∈ {3,6,7} for a load.
  - funct3 ∉ {0,1,2} for a store.
- An errored request produces no write and returns `rsp_err`=1, `rsp_rdata`=0.
- Store: byte enables come from size and lane. Write data is `wdata[7:0]` replicated to all 4 lanes for B, `wdata[15:0]` replicated to both halves for H. The array is updated at the accept edge.
- Load: the array word is sampled at the accept edge. The selected byte/half is shifted to bit 0 and extended (B/H sign, BU/HU zero).
- Every accepted request, loads and stores alike, yields exactly one response, in order.

## Timing
- Reset values: `req_ready`=0 (CLEAR) or 1 (no clear), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, clear counter 0. The pipeline is emptied.
- Clear duration: `req_ready` rises exactly DEPTH cycles after the first rising edge with `rst_n`=1.
- Response: `rsp_valid` is asserted RD_LAT cycles after the accept edge. Throughput is one request per cycle.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data. Only a later accept sees new data; there is no same-edge forwarding.
- Reset mid-operation: in-flight responses are dropped (never emitted) and the clear restarts from word 0. Array contents are undefined only when `CLEAR_ON_RST`=0.
- Outputs not valid in a cycle hold `rsp_rdata`=0 and `rsp_err`=0.

## Structure
- `dmem_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), FSM state enum {CLEAR, RUN}, response struct {valid, rdata, err} used by the latency pipeline.
- Sub-module `mem_align`: combinational. Covers store byte-enable/data replication, load lane extraction/extension, and misalign/illegal-size check. Both loads and stores instantiate it once.
- Top: FSM, clear counter, array with per-byte write, RD_LAT-deep response shift register.

## Test plan
- Reset clear: DEPTH=16, `CLEAR_ON_RST`=1, release reset -> `req_ready` low for exactly 16 cycles; LW of 0x3C then returns 0x00000000, err 0.
- Sized store/load: SW 0x0 = 0x8081_7F01, then LB 0x0 -> 0x00000001, LB 0x3 -> 0xFFFFFF80, LBU 0x3 -> 0x00000080, LH 0x2 -> 0xFFFF8081, LHU 0x0 -> 0x00007F01.
- Byte-lane store: SW 0x4 = 0x11223344, SB 0x5 = 0xAA, SH 0x6 = 0xBEEF, LW 0x4 -> 0xBEEFAA44.
- Errors: LW 0x2, SH 0x1, LB with funct3=3, SW 0x1000 at DEPTH=1024 -> each `rsp_err`=1, `rsp_rdata`=0, and the target word is unchanged on readback.
- Latency/throughput: RD_LAT=3, back-to-back SW 0x8 = 5 then LW 0x8 on consecutive cycles -> responses 3 cycles after each accept, in order; the load returns 5.
- Reset mid-flight: RD_LAT=4, two loads accepted, `rst_n` pulsed low 2 cycles later -> no `rsp_valid` for either load; clear restarts.
